cpu_alu_sequencer: RTL and testbench

// - Multi-cycle controller that sequences the 6502 combinational ALU (cpu_alu)
//   for the CPU core.
// - Accepts one ALU request at a time. Fetches the memory operand when needed,

---
 rtl/cpu_alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_cpu_alu_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_sequencer.sv
// cpu_alu_sequencer: multi-cycle 6502 ALU controller owning N/Z/C/V; define CPU_ALU_SEQ_DUMMY_WRITE_EN for the NMOS RMW dummy write
module cpu_alu_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [1:0]        req_mode,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_imm,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              flag_wr,
  input  logic [3:0]        flag_wdata,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_data,
  output logic              done_wb_acc,
  output logic              done_err
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, DUMMY, WRITE, DONE} state_t;
  state_t            r_state;
  logic [3:0]        r_op;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_imm;
  logic              w_exec;
  logic              w_rmw;
  logic              w_err;
  logic              w_upd_c;
  assign w_exec  = r_state == EXEC;
  assign w_rmw   = r_mode == 2'd2;
  assign w_err   = req_mode == 2'd3 || (req_mode == 2'd2 && !(req_op >= 4'd5 && req_op <= 4'hA));
  assign w_upd_c = r_op < 4'd2 || (r_op >= 4'd5 && r_op <= 4'd8) || r_op == 4'hD;
  assign alu_a   = w_exec ? (w_rmw ? mem_rdata : r_a) : '0;
  assign alu_b   = w_exec && !w_rmw ? (r_mode == 2'd0 ? r_imm : mem_rdata) : '0;
  assign alu_op  = w_exec ? r_op : 4'd0;
  assign alu_cin = flag_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_mode      <= '0;
      r_a         <= '0;
      r_imm       <= '0;
      req_ready   <= 1'b1;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      {flag_n, flag_z, flag_c, flag_v} <= 4'b0100;
      done_valid  <= 1'b0;
      done_data   <= '0;
      done_wb_acc <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flag_wr) {flag_n, flag_z, flag_c, flag_v} <= flag_wdata;
          if (req_valid) begin
            r_op        <= req_op;
            r_mode      <= req_mode;
            r_a         <= req_a;
            r_imm       <= req_imm;
            req_ready   <= 1'b0;
            done_err    <= w_err;
            done_wb_acc <= !w_err && !req_mode[1] && req_op != 4'hD;
            if (w_err) begin
              done_valid <= 1'b1;
              r_state    <= DONE;
            end else if (req_mode == 2'd0) begin
              r_state <= EXEC;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= req_addr;
              r_state  <= READ;
            end
          end
        end
        READ: begin
          mem_rd  <= 1'b0;
          r_state <= EXEC;
        end
        EXEC: begin
          done_data <= alu_result;
          flag_n    <= alu_n;
          flag_z    <= alu_z;
          if (w_upd_c) flag_c <= alu_c;
          if (r_op < 4'd2) flag_v <= alu_v;
          if (w_rmw) begin
            mem_wr <= 1'b1;
`ifdef CPU_ALU_SEQ_DUMMY_WRITE_EN
            mem_wdata <= mem_rdata;
            r_state   <= DUMMY;
`else
            mem_wdata <= alu_result;
            r_state   <= WRITE;
`endif
          end else begin
            done_valid <= 1'b1;
            r_state    <= DONE;
          end
        end
        DUMMY: begin
          mem_wdata <= done_data;
          r_state   <= WRITE;
        end
        WRITE: begin
          mem_wr     <= 1'b0;
          done_valid <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          done_valid <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_alu_sequencer.sv
// tb_cpu_alu_sequencer: directed checks of the ALU sequencer against a behavioural ALU and memory
module tb_cpu_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_mode;
  logic [7:0]  req_a, req_imm;
  logic [15:0] req_addr, mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_c, alu_v, alu_n, alu_z;
  logic        flag_wr;
  logic [3:0]  flag_wdata;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        done_valid, done_wb_acc, done_err;
  logic [7:0]  done_data;
  logic [3:0]  flags;
  logic [7:0]  mem [0:65535];
  logic [7:0]  wr_q [$];
  logic [15:0] last_wr_addr;
  logic [15:0] last_rd_addr;
  int          rd_cnt = 0;
  int          tests = 0;
  int          fails = 0;
  int          lat, nrd, nwr;
  logic [8:0]  m_sum;
  logic [7:0]  m_res;
  logic        m_c, m_v;

  cpu_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_mode(req_mode),
    .req_a(req_a), .req_imm(req_imm), .req_addr(req_addr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin), .alu_result(alu_result),
    .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .flag_wr(flag_wr), .flag_wdata(flag_wdata),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .done_valid(done_valid), .done_data(done_data), .done_wb_acc(done_wb_acc), .done_err(done_err)
  );

  always #5 clk = ~clk;
  assign flags = {flag_n, flag_z, flag_c, flag_v};

  always_comb begin
    m_sum = '0;
    m_res = alu_a;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_op)
      4'h0: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        m_res = m_sum[7:0];
        m_c   = m_sum[8];
        m_v   = (alu_a[7] == alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      4'h1: begin
        m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
        m_res = m_sum[7:0];
        m_c   = m_sum[8];
        m_v   = (alu_a[7] != alu_b[7]) && (m_sum[7] != alu_a[7]);
      end
      4'h2: m_res = alu_a & alu_b;
      4'h3: m_res = alu_a | alu_b;
      4'h4: m_res = alu_a ^ alu_b;
      4'h5: {m_c, m_res} = {alu_a, 1'b0};
      4'h6: {m_res, m_c} = {1'b0, alu_a};
      4'h7: {m_c, m_res} = {alu_a, alu_cin};
      4'h8: {m_res, m_c} = {alu_cin, alu_a};
      4'h9: m_res = alu_a + 8'd1;
      4'hA: m_res = alu_a - 8'd1;
      4'hD: begin
        m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
        m_res = m_sum[7:0];
        m_c   = m_sum[8];
      end
      default: m_res = alu_a;
    endcase
  end
  assign alu_result = m_res;
  assign alu_c      = m_c;
  assign alu_v      = m_v;
  assign alu_n      = m_res[7];
  assign alu_z      = m_res == 8'd0;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      last_rd_addr = mem_addr;
      rd_cnt++;
    end
    if (mem_wr) begin
      mem[mem_addr] = mem_wdata;
      wr_q.push_back(mem_wdata);
      last_wr_addr = mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] mode, input logic [3:0] op, input logic [7:0] a, imm,
                         input logic [15:0] addr, input logic fw, input logic [3:0] fwd,
                         output int l, output int r, output int w);
    int r0, w0;
    @(negedge clk);
    r0 = rd_cnt;
    w0 = wr_q.size();
    req_valid = 1'b1; req_mode = mode; req_op = op; req_a = a; req_imm = imm; req_addr = addr;
    flag_wr = fw; flag_wdata = fwd;
    @(posedge clk);
    l = 1;
    @(negedge clk);
    req_valid = 1'b0;
    flag_wr = 1'b0;
    while (!done_valid && l < 20) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
    r = rd_cnt - r0;
    w = wr_q.size() - w0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_mode = '0; req_a = '0; req_imm = '0;
    req_addr = '0; flag_wr = 1'b0; flag_wdata = '0; mem_rdata = '0;
    last_wr_addr = '0; last_rd_addr = '0;
    mem[16'h0200] = 8'h50;
    mem[16'h0010] = 8'h81;
    mem[16'h0020] = 8'hFF;
    mem[16'h0040] = 8'h80;
    mem[16'h0030] = 8'h05;
    repeat (2) @(negedge clk);
    check("rst_flags", flags, 4'b0100);
    check("rst_ready", req_ready, 1);
    check("rst_done", done_valid, 0);
    check("rst_strobes", {mem_rd, mem_wr}, 0);
    rst_n = 1'b1;

    run_req(2'd0, 4'h0, 8'h50, 8'h30, 16'h0000, 1'b0, 4'h0, lat, nrd, nwr);
    check("add_data", done_data, 8'h80);
    check("add_flags", flags, 4'b1001);
    check("add_wb", done_wb_acc, 1);
    check("add_lat", lat, 2);
    check("add_mem", nrd + nwr, 0);

    run_req(2'd1, 4'hD, 8'h50, 8'h00, 16'h0200, 1'b0, 4'h0, lat, nrd, nwr);
    check("cmp_flags", flags, 4'b0111);
    check("cmp_wb", done_wb_acc, 0);
    check("cmp_lat", lat, 3);
    check("cmp_rd", nrd, 1);
    check("cmp_rd_addr", last_rd_addr, 16'h0200);

    run_req(2'd2, 4'h7, 8'h00, 8'h00, 16'h0010, 1'b1, 4'b0010, lat, nrd, nwr);
    check("rol_data", done_data, 8'h03);
    check("rol_flags", flags, 4'b0010);
    check("rol_last_wr", wr_q[$], 8'h03);
    check("rol_wr_addr", last_wr_addr, 16'h0010);
    check("rol_mem", mem[16'h0010], 8'h03);
    check("rol_wb", done_wb_acc, 0);
`ifdef CPU_ALU_SEQ_DUMMY_WRITE_EN
    check("rol_nwr", nwr, 2);
    check("rol_dummy", wr_q[wr_q.size()-2], 8'h81);
    check("rol_lat", lat, 5);
`else
    check("rol_nwr", nwr, 1);
    check("rol_lat", lat, 4);
`endif

    run_req(2'd2, 4'h9, 8'h00, 8'h00, 16'h0020, 1'b0, 4'h0, lat, nrd, nwr);
    check("inc_mem", mem[16'h0020], 8'h00);
    check("inc_flags", flags, 4'b0110);

    run_req(2'd2, 4'h0, 8'h00, 8'h00, 16'h0020, 1'b0, 4'h0, lat, nrd, nwr);
    check("rmwadd_err", done_err, 1);
    check("rmwadd_mem", nrd + nwr, 0);
    check("rmwadd_flags", flags, 4'b0110);
    check("rmwadd_lat", lat, 1);

    run_req(2'd3, 4'h2, 8'h00, 8'h00, 16'h0000, 1'b0, 4'h0, lat, nrd, nwr);
    check("illegal_err", done_err, 1);
    check("illegal_wb", done_wb_acc, 0);

    run_req(2'd0, 4'h1, 8'h10, 8'h20, 16'h0000, 1'b0, 4'h0, lat, nrd, nwr);
    check("sub_data", done_data, 8'hF0);
    check("sub_flags", flags, 4'b1000);
    check("sub_err", done_err, 0);

    run_req(2'd2, 4'h5, 8'h00, 8'h00, 16'h0040, 1'b0, 4'h0, lat, nrd, nwr);
    check("asl_mem", mem[16'h0040], 8'h00);
    check("asl_flags", flags, 4'b0110);

    @(negedge clk);
    req_valid = 1'b1; req_mode = 2'd2; req_op = 4'hA; req_addr = 16'h0030;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !(mem_wr && mem_wdata == 8'h04); i++) @(negedge clk);
    check("rst_wr_seen", {mem_wr, mem_wdata}, {1'b1, 8'h04});
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr", mem_wr, 0);
    check("rst_mid_flags", flags, 4'b0100);
    check("rst_mid_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("rst_no_write", mem[16'h0030], 8'h05);
    rst_n = 1'b1;

    run_req(2'd0, 4'h2, 8'hF0, 8'h3C, 16'h0000, 1'b0, 4'h0, lat, nrd, nwr);
    check("post_rst_data", done_data, 8'h30);
    check("post_rst_flags", flags, 4'b0000);
    check("post_rst_lat", lat, 2);
    check("post_rst_wb", done_wb_acc, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
